onehot_grant_decoder: RTL and testbench

Registered 3-to-8 decoder that turns an encoded request index into a one-hot grant line and holds it under a handshake. It is the companion to the 8-to-3 priority encoder: the encoder's 3-bit index Y feeds `code`, and this block drives exactly one of eight grant lines. Each line stays asserted until its requester acknowledges it or a hold timeout expires. A programmable gap follows before the next index is accepted.

---
 rtl/onehot_grant_decoder_if.sv | 30 +++
 rtl/onehot_grant_decoder.sv | 115 +++++++++++
 tb/tb_onehot_grant_decoder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/onehot_grant_decoder_if.sv
// onehot_grant_decoder_if
//   Handshake/bus bundle between a requester side (master) and the
//   one-hot grant decoder (slave).
//   code_valid/code/code_ready : encoded request index handshake
//   ack                        : per-line acknowledge (only the granted line matters)
//   Y                          : one-hot grant lines
//   busy/done/timeout          : status; done/timeout are one-cycle end-of-grant pulses
//   seen_clr/seen              : clear strobe and sticky mask of accepted indices
interface onehot_grant_decoder_if;
  logic       code_valid;
  logic [2:0] code;
  logic       code_ready;
  logic [7:0] ack;
  logic [7:0] Y;
  logic       busy;
  logic       done;
  logic       timeout;
  logic       seen_clr;
  logic [7:0] seen;

  modport master (
    output code_valid, code, ack, seen_clr,
    input  code_ready, Y, busy, done, timeout, seen
  );

  modport slave (
    input  code_valid, code, ack, seen_clr,
    output code_ready, Y, busy, done, timeout, seen
  );
endinterface

// File: rtl/onehot_grant_decoder.sv
// onehot_grant_decoder
//   Registered 3-to-8 decoder. Accepts an encoded index, drives the matching
//   one-hot grant line until that line acknowledges or HOLD cycles elapse,
//   then idles GAP cycles before accepting the next index.
//   Parameters: HOLD (1..255) max drive cycles, GAP (0..15) idle cycles.
//   Ports: clk, rst (synchronous, active-high), bus (slave side of
//   onehot_grant_decoder_if: code handshake, ack, Y, busy, done, timeout,
//   seen_clr, seen).
module onehot_grant_decoder #(
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  onehot_grant_decoder_if.slave        bus
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

  localparam logic [7:0] HOLD_INIT = 8'(HOLD);
  localparam logic [3:0] GAP_INIT  = 4'(GAP);
  // With no gap configured a finished grant returns straight to IDLE.
  localparam state_t     END_STATE = (GAP == 0) ? S_IDLE : S_GAP;

  state_t     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic [7:0] y_q, y_d;
  logic       done_q, done_d;
  logic       timeout_q, timeout_d;
  logic [7:0] seen_q, seen_d;
  logic       code_ready;
  logic       accept;
  logic       ack_hit;

  // Ready is held low during reset so nothing is accepted on a reset edge.
  assign code_ready = (state_q == S_IDLE) && !rst;
  assign accept     = bus.code_valid && code_ready;
  assign ack_hit    = bus.ack[code_q];

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    y_d        = y_q;
    done_d     = 1'b0;
    timeout_d  = 1'b0;

    // Clear first so a same-cycle accept leaves its own bit set.
    seen_d = seen_q;
    if (bus.seen_clr) seen_d = '0;
    if (accept)       seen_d[bus.code] = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_DRIVE;
          code_d     = bus.code;
          hold_cnt_d = HOLD_INIT;
          y_d        = 8'b1 << bus.code;
        end
      end
      S_DRIVE: begin
        // Ack takes priority over expiry on the last hold cycle.
        if (ack_hit || (hold_cnt_q == 8'd1)) begin
          state_d   = END_STATE;
          gap_cnt_d = GAP_INIT;
          y_d       = '0;
          done_d    = ack_hit;
          timeout_d = !ack_hit;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q <= 4'd1) state_d = S_IDLE;
        else                   gap_cnt_d = gap_cnt_q - 4'd1;
      end
      default: begin
        state_d = S_IDLE;
        y_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // Latched index and counters are only read after being loaded.
    code_q     <= code_d;
    hold_cnt_q <= hold_cnt_d;
    gap_cnt_q  <= gap_cnt_d;
    if (rst) begin
      state_q   <= S_IDLE;
      y_q       <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      seen_q    <= '0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      seen_q    <= seen_d;
    end
  end

  assign bus.code_ready = code_ready;
  assign bus.Y          = y_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;
  assign bus.seen       = seen_q;

endmodule

// File: tb/tb_onehot_grant_decoder.sv
// tb_onehot_grant_decoder
//   Directed scenarios followed by random traffic. Expected outputs come from
//   a timestamp model: a grant accepted at edge A ends at the first later edge
//   that samples ack on its line, or at edge A+HOLD; the line is high between
//   those edges, the end pulse appears in the cycle after the ending edge, and
//   the block is ready again GAP cycles after that edge.
module tb_onehot_grant_decoder;
  localparam int HOLD = 4;
  localparam int GAP  = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  onehot_grant_decoder_if bus ();

  onehot_grant_decoder #(.HOLD(HOLD), .GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Timestamp reference model
  int         cyc = 0;
  bit         m_in_grant = 1'b0;
  int         m_acc = 0;
  int         m_free_at = 0;
  int         m_pulse_at = -1;
  bit         m_pulse_done = 1'b0;
  logic [2:0] m_line = 3'd0;
  logic [7:0] m_seen = 8'h00;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic v, input logic [2:0] c, input logic [7:0] a,
                      input logic clr, input logic r);
    bit ready_pre;
    bit accept;
    bit rdy_post;
    logic [7:0] y_exp;
    bus.code_valid = v;
    bus.code       = c;
    bus.ack        = a;
    bus.seen_clr   = clr;
    rst            = r;
    ready_pre = !r && !m_in_grant && (cyc >= m_free_at);
    #1;
    chk("code_ready_pre", {7'b0, bus.code_ready}, {7'b0, ready_pre});
    @(posedge clk);
    cyc++;
    if (r) begin
      m_in_grant = 1'b0;
      m_free_at  = cyc;
      m_seen     = 8'h00;
      m_pulse_at = -1;
    end else begin
      accept = ready_pre && v;
      if (m_in_grant && (a[m_line] || (cyc - m_acc == HOLD))) begin
        m_pulse_done = a[m_line];
        m_pulse_at   = cyc;
        m_in_grant   = 1'b0;
        m_free_at    = cyc + GAP;
      end else if (accept) begin
        m_in_grant = 1'b1;
        m_acc      = cyc;
        m_line     = c;
      end
      if (clr)    m_seen = 8'h00;
      if (accept) m_seen[c] = 1'b1;
    end
    #1;
    y_exp    = m_in_grant ? (8'b1 << m_line) : 8'h00;
    rdy_post = !r && !m_in_grant && (cyc >= m_free_at);
    chk("Y", bus.Y, y_exp);
    chk("done", {7'b0, bus.done}, {7'b0, (m_pulse_at == cyc) && m_pulse_done});
    chk("timeout", {7'b0, bus.timeout}, {7'b0, (m_pulse_at == cyc) && !m_pulse_done});
    chk("busy", {7'b0, bus.busy}, {7'b0, m_in_grant || (cyc < m_free_at)});
    chk("code_ready", {7'b0, bus.code_ready}, {7'b0, rdy_post});
    chk("seen", bus.seen, m_seen);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0] stream [3];
    stream[0] = 3'd7; stream[1] = 3'd6; stream[2] = 3'd0;

    // Reset
    step(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 3'd3, 8'h00, 1'b0, 1'b1);
    chk("reset_Y", bus.Y, 8'h00);
    chk("reset_seen", bus.seen, 8'h00);

    // Index 5, acked in the 2nd drive cycle
    step(1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
    chk("t1_Y", bus.Y, 8'h20);
    step(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 3'd0, 8'h20, 1'b0, 1'b0);
    chk("t1_done", {7'b0, bus.done}, 8'h01);
    idle(2);
    chk("t1_seen", bus.seen, 8'h20);

    // Index 2, no ack: times out after HOLD cycles
    step(1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
    idle(6);

    // Index 0 with wrong lines acked, own line acked in 4th drive cycle
    step(1'b1, 3'd0, 8'hFE, 1'b0, 1'b0);
    step(1'b0, 3'd0, 8'hFE, 1'b0, 1'b0);
    step(1'b0, 3'd0, 8'hFE, 1'b0, 1'b0);
    step(1'b0, 3'd0, 8'hFE, 1'b0, 1'b0);
    step(1'b0, 3'd0, 8'hFF, 1'b0, 1'b0);
    chk("t3_done", {7'b0, bus.done}, 8'h01);
    idle(2);

    // Stream 7, 6, 0 with code_valid held, ack in 1st drive cycle
    step(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, stream[k], 8'h00, 1'b0, 1'b0);
      step(1'b1, stream[k], 8'h01 << stream[k], 1'b0, 1'b0);
      step(1'b1, stream[k], 8'h00, 1'b0, 1'b0);
    end
    idle(1);
    chk("t4_seen", bus.seen, 8'hC1);

    // Reset in the 2nd drive cycle of index 4
    step(1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
    chk("t5_Y", bus.Y, 8'h00);
    chk("t5_seen", bus.seen, 8'h00);
    idle(2);

    // Fill seen, then clear together with accepting index 3
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 3'(k), 8'h00, 1'b0, 1'b0);
      step(1'b0, 3'd0, 8'h01 << k, 1'b0, 1'b0);
      step(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    end
    chk("t6_seen_full", bus.seen, 8'hFF);
    step(1'b1, 3'd3, 8'h00, 1'b1, 1'b0);
    chk("t6_seen", bus.seen, 8'h08);
    idle(6);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic       v;
      logic [2:0] c;
      logic [7:0] a;
      logic       clr;
      logic       r;
      v   = ($urandom_range(0, 9) < 7);
      c   = 3'($urandom_range(0, 7));
      a   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      clr = ($urandom_range(0, 19) == 0);
      r   = ($urandom_range(0, 49) == 0);
      step(v, c, a, clr, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
